reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Downstream consumer of the watchdog's reset output.
- Merges watchdog, external-pin and software reset requests with the power-on reset.
- Stretches them into a timed, staged release: peripherals come out of reset first, the CPU last.
- Records the reset cause and a saturating reset-event count in I/O-readable registers, so firmware can tell why it restarted.

Parameters:
- HOLD_CYCLES, 16, cycles both reset outputs stay asserted after the last request deasserts (1..255).
- CPU_DELAY, 4, extra cycles cpu_reset stays high after periph_reset falls (1..255).
- DEBOUNCE, 4, consecutive synchronized low samples of ext_reset_n needed to qualify an external request (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  power-on reset, synchronous, active-high.
- wdt_reset_req  in  1  watchdog reset output, synchronous to clk, level.
- ext_reset_n  in  1  external reset pin, asynchronous, active-low.
- sw_reset_req  in  1  software reset strobe from I/O decode, one cycle.
- cause_write  in  1  write strobe for the cause register.
- cause_in  in  8  write data; 1 bits clear the matching cause bits (W1C).
- periph_reset  out  1  reset to peripherals, registered, active-high.
- cpu_reset  out  1  reset to the CPU, registered, active-high.
- cause_out  out  8  cause register.
- reset_count_out  out  8  count of non-power-on reset events.
- busy  out  1  high in any state other than RUN.

Behaviour:
- External input path:
  - ext_reset_n passes through a two-flop synchronizer.
  - ext_req is asserted once the synchronized value has been low for DEBOUNCE consecutive cycles.
  - ext_req holds while the pin stays low; any high sample clears the debounce counter and ext_req.
- Combined request: req = wdt_reset_req | ext_req | sw_reset_req.
- Events: the rising edge of each source's request, edge-detected per source with a registered previous value.
- State machine: ASSERT, PERIPH_UP, RUN; hold counter hcnt is 8 bit.
- Power-on reset (reset=1):
  - state=ASSERT, hcnt=0, periph_reset=1, cpu_reset=1, busy=1.
  - cause_out=8'h01, reset_count_out=0.
  - Synchronizer and debounce flops go to the idle (pin high) state.
  - Reset dominates every other input.
- ASSERT:
  - Both outputs high.
  - If req=1, hcnt<=0.
  - Otherwise hcnt increments; when hcnt==HOLD_CYCLES-1, go to PERIPH_UP with hcnt<=0.
- PERIPH_UP:
  - periph_reset=0, cpu_reset=1.
  - req=1 returns to ASSERT with hcnt<=0; both outputs high on the next cycle.
  - Otherwise, after CPU_DELAY cycles, go to RUN.
- RUN: both outputs low, busy=0. req=1 goes to ASSERT with hcnt<=0.
- Latency:
  - Request sampled at edge N: both outputs high after edge N.
  - External path adds 2 synchronizer cycles plus DEBOUNCE cycles.
- Release timing: after the last cycle with req=1 (or with reset=1), periph_reset falls after exactly HOLD_CYCLES edges, and cpu_reset falls CPU_DELAY edges after that.
- Cause bits:
  - bit0 POR: set only by reset.
  - bit1 watchdog, bit2 external, bit3 software: set on the event for that source.
  - bits 7:4 always read 0.
  - Simultaneous events set all matching bits in one cycle.
  - A set in the same cycle as a W1C clear of the same bit wins: the bit ends up 1.
  - A held request does not re-set a bit after it has been cleared.
- reset_count_out:
  - Increments by exactly 1 in any cycle with at least one event, however many sources fire.
  - Saturates at 255.
  - Cleared only by reset.
- Requests in ASSERT or PERIPH_UP still record cause and count, and restart the hold.

Test Plan:
- Power-on reset held 3 cycles then released, no requests -> periph_reset falls 16 edges after release, cpu_reset 4 edges later; cause_out=8'h01, reset_count_out=0, busy=0 in RUN.
- In RUN, pulse wdt_reset_req for 1 cycle -> both outputs high the next cycle; release at +16/+20 edges after the pulse cycle; cause_out=8'h03, reset_count_out=1.
- ext_reset_n low for 3 cycles, then for 10 cycles -> the first pulse has no effect; the second qualifies 6 cycles after its falling edge (2 sync + 4 debounce); cause bit2 set; outputs stay high until 16 edges after ext_req drops.
- sw_reset_req and wdt_reset_req in the same cycle while in PERIPH_UP -> back to ASSERT, cause_out=8'h0B, reset_count_out increments by 1 only.
- cause_write with cause_in=8'h0F in the same cycle as an sw_reset_req event -> bits 0..2 cleared, bit3 stays 1; cause_out=8'h08.
- 260 watchdog pulses spaced 30 cycles apart -> reset_count_out stops at 255 and holds; reset clears it to 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges power-on, watchdog, external-pin and software
// reset requests into a timed, staged release (peripherals first, CPU last).
// Ports:
//   clk, reset              - system clock, synchronous active-high POR
//   wdt_reset_req           - watchdog request (level, clk domain)
//   ext_reset_n             - external reset pin (async, active-low)
//   sw_reset_req            - software reset strobe
//   cause_write, cause_in   - W1C write port for the cause register
//   periph_reset, cpu_reset - registered active-high reset outputs
//   cause_out               - {4'b0, sw, ext, wdt, por} cause bits
//   reset_count_out         - saturating count of non-POR reset events
//   busy                    - high whenever the sequencer is not in RUN
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CPU_DELAY   = 4,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wdt_reset_req,
    input  logic       ext_reset_n,
    input  logic       sw_reset_req,
    input  logic       cause_write,
    input  logic [7:0] cause_in,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic [7:0] cause_out,
    output logic [7:0] reset_count_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_PERIPH_UP,
        ST_RUN
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] CPU_LAST  = 8'(CPU_DELAY - 1);
    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hcnt;
    logic [7:0] w_hcnt_nxt;

    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_dcnt;
    logic       r_ext_req;

    logic       r_wdt_prev;
    logic       r_ext_prev;
    logic       r_sw_prev;

    logic       r_periph;
    logic       r_cpu;
    logic [3:0] r_cause;
    logic [7:0] r_count;

    logic       w_req;
    logic       w_wdt_ev;
    logic       w_ext_ev;
    logic       w_sw_ev;
    logic       w_any_ev;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic       w_unused_bits;

    // Two-flop synchronizer, then a low-run debounce. Idle state is
    // "pin high" so a POR never produces a spurious external request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_dcnt    <= 4'd0;
            r_ext_req <= 1'b0;
        end else begin
            r_sync1 <= ext_reset_n;
            r_sync2 <= r_sync1;
            if (r_sync2) begin
                r_dcnt    <= 4'd0;
                r_ext_req <= 1'b0;
            end else if (r_dcnt == DEB_LAST) begin
                r_ext_req <= 1'b1;
            end else begin
                r_dcnt <= r_dcnt + 4'd1;
            end
        end
    end

    assign w_req    = wdt_reset_req | r_ext_req | sw_reset_req;
    assign w_wdt_ev = wdt_reset_req & ~r_wdt_prev;
    assign w_ext_ev = r_ext_req & ~r_ext_prev;
    assign w_sw_ev  = sw_reset_req & ~r_sw_prev;
    assign w_any_ev = w_wdt_ev | w_ext_ev | w_sw_ev;

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        case (r_state)
            ST_ASSERT: begin
                if (w_req) begin
                    w_hcnt_nxt = 8'd0;
                end else if (r_hcnt == HOLD_LAST) begin
                    w_state_nxt = ST_PERIPH_UP;
                    w_hcnt_nxt  = 8'd0;
                end else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
            end
            ST_PERIPH_UP: begin
                if (w_req) begin
                    w_state_nxt = ST_ASSERT;
                    w_hcnt_nxt  = 8'd0;
                end else if (r_hcnt == CPU_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_hcnt_nxt  = 8'd0;
                end else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
            end
            ST_RUN: begin
                if (w_req) begin
                    w_state_nxt = ST_ASSERT;
                    w_hcnt_nxt  = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_hcnt_nxt  = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge that the state does.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ASSERT;
            r_hcnt   <= 8'd0;
            r_periph <= 1'b1;
            r_cpu    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_periph <= (w_state_nxt == ST_ASSERT);
            r_cpu    <= (w_state_nxt != ST_RUN);
        end
    end

    // A set in the same cycle as a clear wins, so set is OR-ed in last.
    assign w_set = {w_sw_ev, w_ext_ev, w_wdt_ev, 1'b0};
    assign w_clr = cause_write ? cause_in[3:0] : 4'd0;
    assign w_unused_bits = ^cause_in[7:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdt_prev <= 1'b0;
            r_ext_prev <= 1'b0;
            r_sw_prev  <= 1'b0;
            r_cause    <= 4'h1;
            r_count    <= 8'd0;
        end else begin
            r_wdt_prev <= wdt_reset_req;
            r_ext_prev <= r_ext_req;
            r_sw_prev  <= sw_reset_req;
            r_cause    <= (r_cause & ~w_clr) | w_set;
            if (w_any_ev && r_count != 8'hFF) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign periph_reset    = r_periph;
    assign cpu_reset       = r_cpu;
    assign cause_out       = {4'd0, r_cause};
    assign reset_count_out = r_count;
    assign busy            = (r_state != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: vector table, hand sequences and random stimulus
// for reset_sequencer, checked against a cycles-since-request model.
module tb_reset_sequencer;

    localparam int HOLD = 16;
    localparam int CDLY = 4;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wdt_reset_req;
    logic       ext_reset_n;
    logic       sw_reset_req;
    logic       cause_write;
    logic [7:0] cause_in;
    logic       periph_reset;
    logic       cpu_reset;
    logic [7:0] cause_out;
    logic [7:0] reset_count_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .CPU_DELAY  (CDLY),
        .DEBOUNCE   (DEB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wdt_reset_req  (wdt_reset_req),
        .ext_reset_n    (ext_reset_n),
        .sw_reset_req   (sw_reset_req),
        .cause_write    (cause_write),
        .cause_in       (cause_in),
        .periph_reset   (periph_reset),
        .cpu_reset      (cpu_reset),
        .cause_out      (cause_out),
        .reset_count_out(reset_count_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Reference model: outputs follow "edges since the last request/POR".
    int         m_since;
    logic [7:0] m_cause;
    logic [7:0] m_cnt;
    logic       m_pw, m_pe, m_ps;
    logic       m_ext;
    logic       hist [0:15];

    task automatic model_step(input logic rst_i, wdt_i, extn_i, sw_i,
                              input logic cw_i, input logic [7:0] ci_i);
        logic req, ew, ee, es, ok;
        if (rst_i) begin
            m_since = 0;
            m_cause = 8'h01;
            m_cnt   = 8'd0;
            m_pw = 1'b0; m_pe = 1'b0; m_ps = 1'b0;
            m_ext = 1'b0;
            for (int k = 0; k < 16; k++) hist[k] = 1'b1;
            return;
        end
        req = wdt_i | sw_i | m_ext;
        ew  = wdt_i & ~m_pw;
        ee  = m_ext & ~m_pe;
        es  = sw_i & ~m_ps;
        if (cw_i) m_cause = m_cause & ~ci_i;
        m_cause = (m_cause | {4'd0, es, ee, ew, 1'b0}) & 8'h0F;
        if ((ew | ee | es) && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        m_pw = wdt_i; m_pe = m_ext; m_ps = sw_i;
        if (req) m_since = 0;
        else if (m_since < 1000) m_since = m_since + 1;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = extn_i;
        // hist[k] is the pin sample k edges ago; the debounced request
        // needs DEB consecutive lows seen through the 2-flop sync.
        ok = 1'b1;
        for (int k = 2; k < 2 + DEB; k++) if (hist[k]) ok = 1'b0;
        m_ext = ok;
    endtask

    function automatic logic [18:0] m_pack();
        logic per, cpu;
        per = (m_since < HOLD);
        cpu = (m_since < HOLD + CDLY);
        return {per, cpu, cpu, m_cause, m_cnt};
    endfunction

    function automatic logic [18:0] act_pack();
        return {periph_reset, cpu_reset, busy, cause_out, reset_count_out};
    endfunction

    task automatic chk(input string name, input logic [18:0] act,
                       input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got per/cpu/busy/cause/cnt=%b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                     name, act[18], act[17], act[16], act[15:8], act[7:0],
                     exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic cycle(input logic rst_i, wdt_i, extn_i, sw_i,
                         input logic cw_i, input logic [7:0] ci_i);
        reset         = rst_i;
        wdt_reset_req = wdt_i;
        ext_reset_n   = extn_i;
        sw_reset_req  = sw_i;
        cause_write   = cw_i;
        cause_in      = ci_i;
        @(posedge clk);
        model_step(rst_i, wdt_i, extn_i, sw_i, cw_i, ci_i);
        #1;
        chk("model", act_pack(), m_pack());
    endtask

    typedef struct {
        int         rep;
        logic       rst, wdt, extn, sw, cw;
        logic [7:0] ci;
        logic       per, cpu, bsy;
        logic [7:0] cause, cnt;
    } vec_t;

    vec_t tbl [23];

    initial begin
        int lowrun;
        logic pin;

        tbl[0]  = '{3,  1,0,1,0,0,8'h00, 1,1,1,8'h01,8'h00};
        tbl[1]  = '{15, 0,0,1,0,0,8'h00, 1,1,1,8'h01,8'h00};
        tbl[2]  = '{1,  0,0,1,0,0,8'h00, 0,1,1,8'h01,8'h00};
        tbl[3]  = '{3,  0,0,1,0,0,8'h00, 0,1,1,8'h01,8'h00};
        tbl[4]  = '{1,  0,0,1,0,0,8'h00, 0,0,0,8'h01,8'h00};
        tbl[5]  = '{1,  0,1,1,0,0,8'h00, 1,1,1,8'h03,8'h01};
        tbl[6]  = '{16, 0,0,1,0,0,8'h00, 0,1,1,8'h03,8'h01};
        tbl[7]  = '{4,  0,0,1,0,0,8'h00, 0,0,0,8'h03,8'h01};
        tbl[8]  = '{1,  0,0,1,1,1,8'h0F, 1,1,1,8'h08,8'h02};
        tbl[9]  = '{16, 0,0,1,0,0,8'h00, 0,1,1,8'h08,8'h02};
        tbl[10] = '{1,  0,1,1,1,0,8'h00, 1,1,1,8'h0A,8'h03};
        tbl[11] = '{15, 0,0,1,0,0,8'h00, 1,1,1,8'h0A,8'h03};
        tbl[12] = '{1,  0,0,1,0,0,8'h00, 0,1,1,8'h0A,8'h03};
        tbl[13] = '{4,  0,0,1,0,1,8'hFF, 0,0,0,8'h00,8'h03};
        tbl[14] = '{3,  0,0,0,0,0,8'h00, 0,0,0,8'h00,8'h03};
        tbl[15] = '{5,  0,0,1,0,0,8'h00, 0,0,0,8'h00,8'h03};
        tbl[16] = '{6,  0,0,0,0,0,8'h00, 0,0,0,8'h00,8'h03};
        tbl[17] = '{1,  0,0,0,0,0,8'h00, 1,1,1,8'h04,8'h04};
        tbl[18] = '{3,  0,0,0,0,0,8'h00, 1,1,1,8'h04,8'h04};
        tbl[19] = '{18, 0,0,1,0,0,8'h00, 1,1,1,8'h04,8'h04};
        tbl[20] = '{1,  0,0,1,0,0,8'h00, 0,1,1,8'h04,8'h04};
        tbl[21] = '{4,  0,0,1,0,0,8'h00, 0,0,0,8'h04,8'h04};
        tbl[22] = '{1,  1,0,1,0,0,8'h00, 1,1,1,8'h01,8'h00};

        for (int i = 0; i < 23; i++) begin
            for (int r = 0; r < tbl[i].rep; r++)
                cycle(tbl[i].rst, tbl[i].wdt, tbl[i].extn, tbl[i].sw,
                      tbl[i].cw, tbl[i].ci);
            chk($sformatf("vec%0d", i), act_pack(),
                {tbl[i].per, tbl[i].cpu, tbl[i].bsy, tbl[i].cause, tbl[i].cnt});
        end

        // Held watchdog request must not re-set a cleared bit.
        cycle(1, 0, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 1, 8'h02);
        cycle(0, 1, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);
        chk("held_no_reset", {3'b111, cause_out, reset_count_out},
            {3'b111, 8'h01, 8'h01});

        // Saturating event count.
        cycle(1, 0, 1, 0, 0, 8'h00);
        for (int p = 0; p < 260; p++) begin
            cycle(0, 1, 1, 0, 0, 8'h00);
            for (int q = 0; q < 29; q++) cycle(0, 0, 1, 0, 0, 8'h00);
        end
        chk("saturate", {3'b000, cause_out, reset_count_out},
            {3'b000, 8'h03, 8'hFF});
        cycle(1, 0, 1, 0, 0, 8'h00);
        chk("sat_clear", act_pack(), {3'b111, 8'h01, 8'h00});

        // Random traffic against the model.
        lowrun = 0;
        pin    = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            if (lowrun > 0) begin
                lowrun--;
                pin = (lowrun == 0);
            end else if ($urandom_range(0, 39) == 0) begin
                lowrun = $urandom_range(1, 12);
                pin    = 1'b0;
            end
            cycle(($urandom_range(0, 999) == 0),
                  ($urandom_range(0, 99) < 3),
                  pin,
                  ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 9) == 0),
                  8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
